// File: rtl/multicycle_controller.sv
// Main control FSM and instruction decoder for the multicycle RV32I core.
// Drives every datapath mux select and write enable from the latched instruction and ALU flags.
module multicycle_controller #(
    parameter bit RESET_PC_FETCH = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       cout,
    input  logic       overflow,
    input  logic       sign,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       RegWrite,
    output logic       illegal
);
    localparam logic [3:0] StFetch    = 4'd0,  StDecode  = 4'd1,  StMemAdr   = 4'd2,
                           StMemRead  = 4'd3,  StMemWb   = 4'd4,  StMemWrite = 4'd5,
                           StExecR    = 4'd6,  StExecI   = 4'd7,  StAluWb    = 4'd8,
                           StBranch   = 4'd9,  StJal     = 4'd10, StJalr1    = 4'd11,
                           StJalr2    = 4'd12, StLui     = 4'd13, StAuipc    = 4'd14,
                           StIllegal  = 4'd15;

    localparam logic [6:0] OpLoad = 7'b0000011, OpStore = 7'b0100011, OpR     = 7'b0110011,
                           OpI    = 7'b0010011, OpBranch = 7'b1100011, OpJal  = 7'b1101111,
                           OpJalr = 7'b1100111, OpLui   = 7'b0110111, OpAuipc = 7'b0010111;

    localparam logic [3:0] AluAdd = 4'd0, AluSub = 4'd1, AluAnd = 4'd2, AluOr   = 4'd3,
                           AluXor = 4'd4, AluSlt = 4'd5, AluSltu = 4'd6, AluSll = 4'd7,
                           AluSrl = 4'd8, AluSra = 4'd9;

    localparam logic [2:0] ImmI = 3'd0, ImmS = 3'd1, ImmB = 3'd2, ImmJ = 3'd3, ImmU = 3'd4;

    logic [3:0] state_q, state_d;
    logic       started_q, started_d;
    logic       fetch_en;
    logic       br_taken, br_bad;
    logic [2:0] imm_dec;
    logic [3:0] alu_fn;

    // Without auto-start, the first go seen in FETCH both starts this fetch and latches the start.
    assign fetch_en  = RESET_PC_FETCH || started_q || go;
    assign started_d = started_q || ((state_q == StFetch) && go);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            started_q <= started_d;
        end
    end

    always_comb begin
        unique case (op)
            OpStore:        imm_dec = ImmS;
            OpBranch:       imm_dec = ImmB;
            OpJal:          imm_dec = ImmJ;
            OpLui, OpAuipc: imm_dec = ImmU;
            default:        imm_dec = ImmI;
        endcase
    end

    always_comb begin
        unique case (funct3)
            3'b000:  alu_fn = ((op == OpR) && funct7b5) ? AluSub : AluAdd;
            3'b001:  alu_fn = AluSll;
            3'b010:  alu_fn = AluSlt;
            3'b011:  alu_fn = AluSltu;
            3'b100:  alu_fn = AluXor;
            3'b101:  alu_fn = funct7b5 ? AluSra : AluSrl;
            3'b110:  alu_fn = AluOr;
            default: alu_fn = AluAnd;
        endcase
    end

    // Flags come from SUB of rs1-rs2; cout=1 means no borrow, i.e. rs1 >= rs2 unsigned.
    always_comb begin
        br_bad = 1'b0;
        unique case (funct3)
            3'b000:  br_taken = Zero;
            3'b001:  br_taken = !Zero;
            3'b100:  br_taken = sign ^ overflow;
            3'b101:  br_taken = !(sign ^ overflow);
            3'b110:  br_taken = !cout;
            3'b111:  br_taken = cout;
            default: begin
                br_taken = 1'b0;
                br_bad   = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 3'b000;
        ALUControl = AluAdd;
        RegWrite   = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            StFetch: begin
                if (fetch_en) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    state_d   = StDecode;
                end
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = imm_dec;
                unique case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpR:             state_d = StExecR;
                    OpI:             state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr1;
                    OpLui:           state_d = StLui;
                    OpAuipc:         state_d = StAuipc;
                    default:         state_d = StIllegal;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OpStore) ? ImmS : ImmI;
                state_d = (op == OpStore) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                AdrSrc  = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = StFetch;
            end
            StMemWrite: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                state_d  = StFetch;
            end
            StExecR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_fn;
                state_d    = StAluWb;
            end
            StExecI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ImmSrc     = ImmI;
                ALUControl = alu_fn;
                state_d    = StAluWb;
            end
            StAluWb: begin
                RegWrite = 1'b1;
                state_d  = StFetch;
            end
            StBranch: begin
                ALUSrcA    = 2'b10;
                ALUControl = AluSub;
                ImmSrc     = ImmB;
                PCWrite    = br_taken;
                illegal    = br_bad;
                state_d    = StFetch;
            end
            StJal: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = StAluWb;
            end
            StJalr1: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = ImmI;
                state_d = StJalr2;
            end
            StJalr2: begin
                PCWrite = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                state_d = StAluWb;
            end
            StLui: begin
                ImmSrc    = ImmU;
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
                state_d   = StFetch;
            end
            StAuipc: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = ImmU;
                state_d = StAluWb;
            end
            StIllegal: begin
                illegal = 1'b1;
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
        // Outputs go quiet the instant reset rises, without waiting for a clock edge.
        if (reset) begin
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ImmSrc     = 3'b000;
            ALUControl = AluAdd;
            RegWrite   = 1'b0;
            illegal    = 1'b0;
        end
    end
endmodule
